// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch (IM)
// and load/store (DM). DM wins ties by default. After MAX_DM_RUN back-to-back
// DM wins while IM waits, the next tie goes to IM. Memory latency is converted
// into a one-cycle ack pulse on each requester side. A stalled access is
// aborted with an error after TIMEOUT cycles.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_DM_RUN = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              im_req_i,
  input  logic [ADDR_W-1:0] im_addr_i,
  output logic              im_ack_o,
  output logic [DATA_W-1:0] im_dout_o,
  output logic              im_err_o,
  input  logic              dm_req_i,
  input  logic              dm_wen_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_din_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_dout_o,
  output logic              dm_err_o,
  output logic              mem_en_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i,
  input  logic              mem_ready_i
);

  localparam int RUN_W = 4;   // holds 1..15
  localparam int TO_W  = 16;  // holds 1..65535

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic              owner_dm;    // 1 = current access belongs to DM
  logic [RUN_W-1:0]  dm_run_cnt;  // consecutive DM wins while IM was waiting
  logic [TO_W-1:0]   to_cnt;      // BUSY cycles already spent on this access
  logic              any_req;
  logic              grant_dm;
  logic              timed_out;
  logic              finish;

  // Arbitration decision and end-of-access detection
  always_comb begin
    any_req   = im_req_i | dm_req_i;
    grant_dm  = dm_req_i & (~im_req_i | (dm_run_cnt != RUN_W'(MAX_DM_RUN)));
    timed_out = (to_cnt == TO_W'(TIMEOUT - 1));
    finish    = mem_ready_i | timed_out;
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (finish)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs, grant bookkeeping, run and timeout counters
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner_dm   <= 1'b0;
      dm_run_cnt <= '0;
      to_cnt     <= '0;
      im_ack_o   <= 1'b0;
      im_dout_o  <= '0;
      im_err_o   <= 1'b0;
      dm_ack_o   <= 1'b0;
      dm_dout_o  <= '0;
      dm_err_o   <= 1'b0;
      mem_en_o   <= 1'b0;
      mem_wen_o  <= 1'b0;
      mem_addr_o <= '0;
      mem_din_o  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner_dm   <= grant_dm;
            mem_en_o   <= 1'b1;
            mem_addr_o <= grant_dm ? dm_addr_i : im_addr_i;
            mem_wen_o  <= grant_dm & dm_wen_i;
            mem_din_o  <= grant_dm ? dm_din_i : '0;
            // Only DM wins that made IM wait count towards the run limit.
            if (grant_dm && im_req_i) begin
              if (dm_run_cnt != RUN_W'(MAX_DM_RUN))
                dm_run_cnt <= dm_run_cnt + 1'b1;
            end else begin
              dm_run_cnt <= '0;
            end
          end
        end
        BUSY: begin
          to_cnt <= to_cnt + 1'b1;
          if (finish) begin
            mem_en_o  <= 1'b0;
            mem_wen_o <= 1'b0;
            to_cnt    <= '0;
            // A real completion wins over a timeout in the same cycle.
            if (owner_dm) begin
              dm_ack_o  <= 1'b1;
              dm_err_o  <= ~mem_ready_i;
              dm_dout_o <= (mem_ready_i && !mem_wen_o) ? mem_dout_i : '0;
            end else begin
              im_ack_o  <= 1'b1;
              im_err_o  <= ~mem_ready_i;
              im_dout_o <= mem_ready_i ? mem_dout_i : '0;
            end
          end
        end
        DONE: begin
          im_ack_o  <= 1'b0;
          im_dout_o <= '0;
          im_err_o  <= 1'b0;
          dm_ack_o  <= 1'b0;
          dm_dout_o <= '0;
          dm_err_o  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
